// File: rtl/proc_nios2_qsys_0_oci_dct_packer.sv
// proc_nios2_qsys_0_oci_dct_packer
//
// Packs 2-bit conditional-branch outcome codes from the OCI instruction-trace
// path into a 30-bit, 15-slot direct-conditional-trace buffer. A full buffer,
// or a non-empty buffer on flush/trace-disable, is handed to a single-entry
// valid/ready holding register that feeds the trace FIFO.
//
// Ports:
//   clk         system clock, rising edge
//   reset_n     asynchronous active-low reset
//   trc_on      trace enable from OCI control
//   br_valid    conditional branch retired this cycle
//   br_code     outcome code (01 not taken, 10 taken, 11 taken+exception, 00 ignored)
//   flush       emit the partial buffer
//   pkt_ready   downstream accepts the packet
//   ovf_clr     clears the sticky overflow flag
//   dct_buffer  live accumulating buffer, newest code at [1:0]
//   dct_count   live code count, 0..14
//   pkt_valid   holding register full
//   pkt_data    {count[3:0], buffer[29:0]}
//   overflow    sticky, a packet was dropped
module proc_nios2_qsys_0_oci_dct_packer #(
  parameter int ENTRIES = 15,
  parameter int CODE_W  = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        trc_on,
  input  logic        br_valid,
  input  logic [1:0]  br_code,
  input  logic        flush,
  input  logic        pkt_ready,
  input  logic        ovf_clr,
  output logic [29:0] dct_buffer,
  output logic [3:0]  dct_count,
  output logic        pkt_valid,
  output logic [33:0] pkt_data,
  output logic        overflow
);

  localparam logic [0:0] ST_OFF = 1'b0;
  localparam logic [0:0] ST_RUN = 1'b1;
  localparam logic [3:0] LAST_COUNT = 4'(ENTRIES);

  logic [0:0]  state_q, state_d;
  logic [29:0] buf_q, buf_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        valid_q, valid_d;
  logic [33:0] data_q, data_d;
  logic        ovf_q, ovf_d;

  logic        active;
  logic        implicitFlush;
  logic        doInsert;
  logic        doFlush;
  logic        emit;
  logic [29:0] nb;
  logic [3:0]  nc;

  // The first cycle with trc_on high already accepts codes, so the block is
  // active either when already in RUN or when trace is being turned on now.
  // Dropping trc_on while in RUN still accepts a code in that same cycle and
  // then flushes whatever is buffered.
  always_comb begin
    active        = (state_q == ST_RUN) || trc_on;
    implicitFlush = (state_q == ST_RUN) && !trc_on;
    doInsert      = active && br_valid && (br_code != 2'b00);
    doFlush       = active && (flush || implicitFlush);
    nb            = doInsert ? {buf_q[29-CODE_W:0], br_code} : buf_q;
    nc            = doInsert ? cnt_q + 4'd1 : cnt_q;
    emit          = (doInsert && (nc == LAST_COUNT)) || (doFlush && (nc != 4'd0));
  end

  // Next-state for FSM, live buffer, holding register and overflow flag.
  // The holding register reloads when empty or when its current packet is
  // leaving this cycle; otherwise an emitted packet is dropped and flagged.
  always_comb begin
    state_d = trc_on ? ST_RUN : ST_OFF;
    buf_d   = nb;
    cnt_d   = nc;
    valid_d = valid_q;
    data_d  = data_q;
    ovf_d   = ovf_q;
    if (emit) begin
      buf_d = '0;
      cnt_d = '0;
    end
    if (emit && (!valid_q || pkt_ready)) begin
      valid_d = 1'b1;
      data_d  = {nc, nb};
    end else if (pkt_ready) begin
      valid_d = 1'b0;
    end
    if (emit && valid_q && !pkt_ready) begin
      ovf_d = 1'b1;
    end else if (ovf_clr) begin
      ovf_d = 1'b0;
    end
  end

  // All state, and therefore every output, is registered.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_OFF;
      buf_q   <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      data_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      ovf_q   <= ovf_d;
    end
  end

  assign dct_buffer = buf_q;
  assign dct_count  = cnt_q;
  assign pkt_valid  = valid_q;
  assign pkt_data   = data_q;
  assign overflow   = ovf_q;

endmodule

// File: tb/tb_proc_nios2_qsys_0_oci_dct_packer.sv
// Directed, table-driven bench for proc_nios2_qsys_0_oci_dct_packer.
// Each table row is one clock cycle of inputs plus the outputs expected just
// after that clock edge.
module tb_proc_nios2_qsys_0_oci_dct_packer;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        trc_on, br_valid, flush, pkt_ready, ovf_clr;
  logic [1:0]  br_code;
  logic [29:0] dct_buffer;
  logic [3:0]  dct_count;
  logic        pkt_valid;
  logic [33:0] pkt_data;
  logic        overflow;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        trc;
    logic        bv;
    logic [1:0]  code;
    logic        fl;
    logic        rdy;
    logic        clr;
    logic [29:0] eBuf;
    logic [3:0]  eCnt;
    logic        eValid;
    logic [33:0] eData;
    logic        eOvf;
  } vec_t;

  vec_t vecs[$];

  proc_nios2_qsys_0_oci_dct_packer dut (
    .clk        (clock),
    .reset_n    (reset_n),
    .trc_on     (trc_on),
    .br_valid   (br_valid),
    .br_code    (br_code),
    .flush      (flush),
    .pkt_ready  (pkt_ready),
    .ovf_clr    (ovf_clr),
    .dct_buffer (dct_buffer),
    .dct_count  (dct_count),
    .pkt_valid  (pkt_valid),
    .pkt_data   (pkt_data),
    .overflow   (overflow)
  );

  always #5 clock = ~clock;

  function automatic void addVec(logic trc, logic bv, logic [1:0] code, logic fl,
                                 logic rdy, logic clr, logic [29:0] eBuf,
                                 logic [3:0] eCnt, logic eValid, logic [33:0] eData,
                                 logic eOvf);
    vec_t v;
    v.trc = trc; v.bv = bv; v.code = code; v.fl = fl; v.rdy = rdy; v.clr = clr;
    v.eBuf = eBuf; v.eCnt = eCnt; v.eValid = eValid; v.eData = eData; v.eOvf = eOvf;
    vecs.push_back(v);
  endfunction

  task automatic checkField(string name, int idx, logic [33:0] got, logic [33:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s step %0d: got %h expected %h", name, idx, got, exp);
    end
  endtask

  task automatic checkOutput(int idx, logic [29:0] eBuf, logic [3:0] eCnt,
                             logic eValid, logic [33:0] eData, logic eOvf,
                             logic checkData);
    checkField("dct_buffer", idx, 34'(dct_buffer), 34'(eBuf));
    checkField("dct_count",  idx, 34'(dct_count),  34'(eCnt));
    checkField("pkt_valid",  idx, 34'(pkt_valid),  34'(eValid));
    checkField("overflow",   idx, 34'(overflow),   34'(eOvf));
    if (checkData) checkField("pkt_data", idx, pkt_data, eData);
  endtask

  // Inputs are driven 1 time unit after a rising edge and outputs sampled
  // 1 time unit after the following rising edge.
  task automatic applyStimulus(vec_t v);
    trc_on    = v.trc;
    br_valid  = v.bv;
    br_code   = v.code;
    flush     = v.fl;
    pkt_ready = v.rdy;
    ovf_clr   = v.clr;
    @(posedge clock);
    #1;
  endtask

  initial begin
    logic [29:0] b;

    // Full packet: fifteen taken codes with the downstream ready.
    b = '0;
    for (int k = 1; k <= 14; k++) begin
      b = (b << 2) | 30'd2;
      addVec(1, 1, 2'b10, 0, 1, 0, b, 4'(k), 0, '0, 0);
    end
    addVec(1, 1, 2'b10, 0, 1, 0, '0, 0, 1, {4'hF, 30'h2AAAAAAA}, 0);
    addVec(1, 0, 2'b00, 0, 1, 0, '0, 0, 0, '0, 0);

    // Partial flush, then a flush of an empty buffer.
    addVec(1, 1, 2'b01, 0, 1, 0, 30'h1,  1, 0, '0, 0);
    addVec(1, 1, 2'b10, 0, 1, 0, 30'h6,  2, 0, '0, 0);
    addVec(1, 1, 2'b11, 0, 1, 0, 30'h1B, 3, 0, '0, 0);
    addVec(1, 0, 2'b00, 1, 1, 0, '0, 0, 1, {4'h3, 30'h1B}, 0);
    addVec(1, 0, 2'b00, 1, 1, 0, '0, 0, 0, '0, 0);

    // Insert and flush in the same cycle.
    addVec(1, 1, 2'b01, 0, 1, 0, 30'h1, 1, 0, '0, 0);
    addVec(1, 1, 2'b01, 0, 1, 0, 30'h5, 2, 0, '0, 0);
    addVec(1, 1, 2'b11, 1, 1, 0, '0, 0, 1, {4'h3, 30'h17}, 0);
    addVec(1, 0, 2'b00, 0, 1, 0, '0, 0, 0, '0, 0);

    // Back-to-back: a new emit while the held packet transfers.
    addVec(1, 1, 2'b01, 0, 0, 0, 30'h1, 1, 0, '0, 0);
    addVec(1, 0, 2'b00, 1, 0, 0, '0, 0, 1, {4'h1, 30'h1}, 0);
    addVec(1, 1, 2'b11, 1, 1, 0, '0, 0, 1, {4'h1, 30'h3}, 0);
    addVec(1, 0, 2'b00, 0, 1, 0, '0, 0, 0, '0, 0);

    // Backpressure and overflow, including set-beats-clear.
    addVec(1, 1, 2'b01, 0, 0, 0, 30'h1, 1, 0, '0, 0);
    addVec(1, 0, 2'b00, 1, 0, 0, '0, 0, 1, {4'h1, 30'h1}, 0);
    addVec(1, 1, 2'b10, 0, 0, 0, 30'h2, 1, 1, {4'h1, 30'h1}, 0);
    addVec(1, 0, 2'b00, 1, 0, 0, '0, 0, 1, {4'h1, 30'h1}, 1);
    addVec(1, 0, 2'b00, 0, 0, 0, '0, 0, 1, {4'h1, 30'h1}, 1);
    addVec(1, 1, 2'b01, 0, 0, 0, 30'h1, 1, 1, {4'h1, 30'h1}, 1);
    addVec(1, 0, 2'b00, 1, 0, 1, '0, 0, 1, {4'h1, 30'h1}, 1);
    addVec(1, 0, 2'b00, 0, 0, 1, '0, 0, 1, {4'h1, 30'h1}, 0);
    addVec(1, 0, 2'b00, 0, 1, 0, '0, 0, 0, '0, 0);

    // Trace disable with a code in the same cycle, then OFF ignores input.
    addVec(1, 1, 2'b01, 0, 1, 0, 30'h1,  1, 0, '0, 0);
    addVec(1, 1, 2'b10, 0, 1, 0, 30'h6,  2, 0, '0, 0);
    addVec(1, 1, 2'b11, 0, 1, 0, 30'h1B, 3, 0, '0, 0);
    addVec(0, 1, 2'b01, 0, 1, 0, '0, 0, 1, {4'h4, 30'h6D}, 0);
    addVec(0, 1, 2'b10, 0, 1, 0, '0, 0, 0, '0, 0);
    addVec(0, 1, 2'b11, 1, 1, 0, '0, 0, 0, '0, 0);
    addVec(1, 1, 2'b00, 0, 1, 0, '0, 0, 0, '0, 0);
    addVec(1, 1, 2'b01, 0, 1, 0, 30'h1, 1, 0, '0, 0);
    addVec(1, 1, 2'b00, 0, 1, 0, 30'h1, 1, 0, '0, 0);
    addVec(0, 0, 2'b00, 0, 1, 0, '0, 0, 1, {4'h1, 30'h1}, 0);
    addVec(0, 0, 2'b00, 0, 1, 0, '0, 0, 0, '0, 0);

    reset_n = 1'b0;
    trc_on = 0; br_valid = 0; br_code = 0; flush = 0; pkt_ready = 0; ovf_clr = 0;
    repeat (2) @(posedge clock);
    #1;
    checkOutput(-1, '0, 0, 0, '0, 0, 1);
    reset_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i]);
      checkOutput(i, vecs[i].eBuf, vecs[i].eCnt, vecs[i].eValid, vecs[i].eData,
                  vecs[i].eOvf, vecs[i].eValid);
    end

    // Reset mid-operation with a packet held and codes buffered.
    trc_on = 1; br_valid = 1; br_code = 2'b10; flush = 0; pkt_ready = 0; ovf_clr = 0;
    @(posedge clock); #1;
    flush = 1;
    @(posedge clock); #1;
    flush = 0; br_code = 2'b01;
    @(posedge clock); #1;
    checkOutput(100, 30'h1, 1, 1, {4'h2, 30'hA}, 0, 1);
    br_valid = 0;
    #2;
    reset_n = 1'b0;
    #1;
    checkOutput(101, '0, 0, 0, '0, 0, 1);
    @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock); #1;
    br_valid = 1; br_code = 2'b11;
    @(posedge clock); #1;
    checkOutput(102, 30'h3, 1, 0, '0, 0, 1);
    br_valid = 0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
